// File: rtl/ls_frame_sequencer_pkg.sv
// Shared parameters and types for the frame sequencer.
// Holds the default geometry (planes, rows, columns), the APB bus widths,
// the register map of the separator (CTRL at 0, coefficient banks from 1)
// and the CTRL start value, plus the state enumerations.
package ls_frame_sequencer_pkg;

    localparam int N_PLANES   = 16;
    localparam int ROWS       = 32;
    localparam int COLS       = 32;
    localparam int APB_ADDR_W = 20;
    localparam int APB_DATA_W = 32;

    localparam int CTRL_ADDR  = 0;
    localparam int BANK_BASE  = 1;
    localparam int CTRL_START = 2;

    localparam int COEF_W     = 12;
    localparam int COEF_DEPTH = 16;

    typedef enum logic [3:0] {
        IDLE,
        CFG_SETUP,
        CFG_ACCESS,
        CFG_GAP,
        ST_SETUP,
        ST_ACCESS,
        FEED,
        DRAIN,
        SP_SETUP,
        SP_ACCESS,
        SP_GAP,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } apb_phase_t;

    // Two 12-bit coefficients are packed per bank word.
    function automatic int bank_count(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/ls_frame_sequencer_apb.sv
// ls_apb_write_master: issues one APB write per req.
// A req seen while idle latches addr/wdata and runs SETUP then ACCESS;
// the cycle after ACCESS the bus is idle again, which gives the gap.
// Ports: clk, rst (sync, active high), req/addr/wdata from the sequencer,
// ack high during the ACCESS cycle, APB outputs PADDR/PSEL/PENABLE/PWRITE/PWDATA.
module ls_apb_write_master
    import ls_frame_sequencer_pkg::*;
#(
    parameter int Amba_Addr_Depth = APB_ADDR_W,
    parameter int Amba_Word       = APB_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [Amba_Addr_Depth-1:0] addr,
    input  logic [Amba_Word-1:0]       wdata,
    output logic                       ack,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA
);

    apb_phase_t phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (req) begin
                        phase  <= PH_SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= addr;
                        PWDATA <= wdata;
                    end
                end
                PH_SETUP: begin
                    phase   <= PH_ACCESS;
                    PENABLE <= 1'b1;
                end
                PH_ACCESS: begin
                    phase   <= PH_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign ack    = (phase == PH_ACCESS);
    assign PWRITE = 1'b1;

endmodule

// File: rtl/ls_frame_sequencer.sv
// ls_frame_sequencer: frame controller for the plane separator.
// Loads the coefficient table over APB, starts the separator, feeds
// N*Row*Col input pixels, drains Row*Col outputs, then stops it.
// Ports: clk, rst (sync, active high); start, coef_wr/coef_idx/coef_data;
// status busy/done/err; APB master PADDR/PSEL/PENABLE/PWRITE/PWDATA;
// pixel request pix_valid/pix_plane/pix_row/pix_col;
// output strobe out_valid/out_row/out_col.
//
// state      | meaning
// IDLE       | waiting for start, coefficient table writable
// CFG_SETUP  | bank word write, setup phase
// CFG_ACCESS | bank word write, access phase
// CFG_GAP    | idle bus cycle between bank writes
// ST_SETUP   | CTRL start write, setup phase
// ST_ACCESS  | CTRL start write, access phase
// FEED       | one input pixel per cycle
// DRAIN      | one latency cycle, then one output per cycle
// SP_SETUP   | CTRL stop write, setup phase
// SP_ACCESS  | CTRL stop write, access phase
// SP_GAP     | idle bus cycle after the stop write
// DONE       | one-cycle done pulse
module ls_frame_sequencer
    import ls_frame_sequencer_pkg::*;
#(
    parameter int N               = N_PLANES,
    parameter int Row             = ROWS,
    parameter int Col             = COLS,
    parameter int Amba_Addr_Depth = APB_ADDR_W,
    parameter int Amba_Word       = APB_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       coef_wr,
    input  logic [3:0]                 coef_idx,
    input  logic [11:0]                coef_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA,
    output logic                       pix_valid,
    output logic [3:0]                 pix_plane,
    output logic [5:0]                 pix_row,
    output logic [5:0]                 pix_col,
    output logic                       out_valid,
    output logic [5:0]                 out_row,
    output logic [5:0]                 out_col
);

    localparam logic [2:0] LAST_BANK  = 3'(bank_count(N) - 1);
    localparam logic [3:0] LAST_PLANE = 4'(N - 1);
    localparam logic [5:0] LAST_ROW   = 6'(Row - 1);
    localparam logic [5:0] LAST_COL   = 6'(Col - 1);

    seq_state_t                 state;
    logic [2:0]                 bank;
    logic [COEF_W-1:0]          coef      [COEF_DEPTH];
    logic [COEF_W-1:0]          coef_view [COEF_DEPTH];
    logic [2:0]                 bank_sel;
    logic [COEF_W-1:0]          coef_lo;
    logic [COEF_W-1:0]          coef_hi;
    logic                       req;
    logic                       ack;
    logic [Amba_Addr_Depth-1:0] req_addr;
    logic [Amba_Word-1:0]       req_data;

    // A write arriving together with start must already be in the first bank word.
    always_comb begin
        coef_view = coef;
        if (state == IDLE && coef_wr) coef_view[coef_idx] = coef_data;
    end

    // Writes are requested one cycle ahead so the bus phases line up with the states.
    always_comb begin
        bank_sel = (state == CFG_GAP) ? bank + 3'd1 : 3'd0;
        coef_lo  = coef_view[{bank_sel, 1'b0}];
        coef_hi  = (2 * int'(bank_sel) + 1 < N) ? coef_view[{bank_sel, 1'b1}] : '0;
        req      = 1'b0;
        req_addr = '0;
        req_data = '0;
        case (state)
            IDLE: begin
                req      = start;
                req_addr = Amba_Addr_Depth'(BANK_BASE);
                req_data = Amba_Word'({coef_hi, coef_lo});
            end
            CFG_GAP: begin
                req = 1'b1;
                if (bank == LAST_BANK) begin
                    req_addr = Amba_Addr_Depth'(CTRL_ADDR);
                    req_data = Amba_Word'(CTRL_START);
                end else begin
                    req_addr = Amba_Addr_Depth'(BANK_BASE) + Amba_Addr_Depth'(bank_sel);
                    req_data = Amba_Word'({coef_hi, coef_lo});
                end
            end
            DRAIN: begin
                req      = out_valid && out_row == LAST_ROW && out_col == LAST_COL;
                req_addr = Amba_Addr_Depth'(CTRL_ADDR);
            end
            default: ;
        endcase
    end

    ls_apb_write_master #(
        .Amba_Addr_Depth(Amba_Addr_Depth),
        .Amba_Word      (Amba_Word)
    ) u_apb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr   (req_addr),
        .wdata  (req_data),
        .ack    (ack),
        .PADDR  (PADDR),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PWDATA (PWDATA)
    );

    assign err = start && busy && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bank      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_plane <= '0;
            pix_row   <= '0;
            pix_col   <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            for (int i = 0; i < COEF_DEPTH; i++) coef[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_wr) coef[coef_idx] <= coef_data;
                    if (start) begin
                        state <= CFG_SETUP;
                        bank  <= '0;
                        busy  <= 1'b1;
                    end
                end
                CFG_SETUP:  state <= CFG_ACCESS;
                CFG_ACCESS: if (ack) state <= CFG_GAP;
                CFG_GAP: begin
                    if (bank == LAST_BANK) begin
                        state <= ST_SETUP;
                    end else begin
                        bank  <= bank + 3'd1;
                        state <= CFG_SETUP;
                    end
                end
                ST_SETUP:   state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (ack) begin
                        state     <= FEED;
                        pix_valid <= 1'b1;
                    end
                end
                FEED: begin
                    if (pix_col != LAST_COL) begin
                        pix_col <= pix_col + 6'd1;
                    end else begin
                        pix_col <= '0;
                        if (pix_row != LAST_ROW) begin
                            pix_row <= pix_row + 6'd1;
                        end else begin
                            pix_row <= '0;
                            if (pix_plane != LAST_PLANE) begin
                                pix_plane <= pix_plane + 4'd1;
                            end else begin
                                pix_plane <= '0;
                                pix_valid <= 1'b0;
                                state     <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // out_valid low marks the separator's one-cycle latency slot.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_col != LAST_COL) begin
                        out_col <= out_col + 6'd1;
                    end else begin
                        out_col <= '0;
                        if (out_row != LAST_ROW) begin
                            out_row <= out_row + 6'd1;
                        end else begin
                            out_row   <= '0;
                            out_valid <= 1'b0;
                            state     <= SP_SETUP;
                        end
                    end
                end
                SP_SETUP:  state <= SP_ACCESS;
                SP_ACCESS: if (ack) state <= SP_GAP;
                SP_GAP: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
